// File: rtl/serout.sv
`default_nettype none
// ============================================================================
// serout : PDP-6 IO-bus serial character output (DATAO/CONO/CONI, LSB-first async frame)
// Rev 1.0
// ============================================================================
module serout #(
  parameter logic [6:0] DEVCODE   = 7'b001_011_0,
  parameter int         BIT_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iobus_iob_poweron,
  input  logic        iobus_iob_reset,
  input  logic        iobus_datao_clear,
  input  logic        iobus_datao_set,
  input  logic        iobus_cono_clear,
  input  logic        iobus_cono_set,
  input  logic        iobus_iob_fm_datai,
  input  logic        iobus_iob_fm_status,
  input  logic        iobus_rdi_pulse,
  input  logic [3:9]  iobus_ios,
  input  logic [0:35] iobus_iob_in,
  output logic [1:7]  iobus_pi_req,
  output logic [0:35] iobus_iob_out,
  output logic        iobus_dr_split,
  output logic        iobus_rdi_data,
  output logic        txd
);

  // Stop phase is two bit times long, so the tick counter must reach 2*BIT_TICKS-1.
  localparam int TW = $clog2(2 * BIT_TICKS);
  localparam logic [TW-1:0] c_bit_end  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] c_stop_end = TW'(2 * BIT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_buf;
  logic          r_pend;
  logic [7:0]    r_shreg;
  logic [2:0]    r_pia;
  logic          r_done;
  logic          r_busy;
  logic [3:0]    r_bitcnt;
  logic [TW-1:0] r_tick;
  logic          r_txd;

  logic          w_sel;
  logic          w_bus_clr;
  logic [7:0]    w_buf_base;
  logic [2:0]    w_pia_base;
  logic [0:35]   w_iob_out;
  logic          w_unused;

  assign w_sel      = (iobus_ios == DEVCODE);
  assign w_bus_clr  = iobus_iob_reset | iobus_iob_poweron;
  assign w_buf_base = (w_sel && iobus_datao_clear) ? 8'd0 : r_buf;
  assign w_pia_base = (w_sel && iobus_cono_clear)  ? 3'd0 : r_pia;
  assign w_unused   = ^{iobus_iob_fm_datai, iobus_rdi_pulse, iobus_iob_in[0:27]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_buf    <= 8'd0;
      r_pend   <= 1'b0;
      r_shreg  <= 8'd0;
      r_pia    <= 3'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_bitcnt <= 4'd0;
      r_tick   <= '0;
      r_txd    <= 1'b1;
    end else if (w_bus_clr) begin
      r_state  <= S_IDLE;
      r_buf    <= 8'd0;
      r_pend   <= 1'b0;
      r_shreg  <= 8'd0;
      r_pia    <= 3'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_bitcnt <= 4'd0;
      r_tick   <= '0;
      r_txd    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_shreg <= r_buf;
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
            r_tick  <= '0;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_tick == c_bit_end) begin
            r_tick   <= '0;
            r_bitcnt <= 4'd0;
            r_txd    <= r_shreg[0];
            r_state  <= S_DATA;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_DATA: begin
          if (r_tick == c_bit_end) begin
            r_tick   <= '0;
            r_shreg  <= {1'b0, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_txd <= r_shreg[1];
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_STOP: begin
          if (r_tick == c_stop_end) begin
            r_tick <= '0;
            if (r_pend) begin
              // Chain straight into the next start bit with no idle gap.
              r_shreg <= r_buf;
              r_pend  <= 1'b0;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Bus writes come after the FSM so a DATAO coinciding with frame end keeps done low.
      if (w_sel && iobus_datao_set) begin
        r_buf  <= w_buf_base | iobus_iob_in[28:35];
        r_pend <= 1'b1;
        r_done <= 1'b0;
      end else if (w_sel && iobus_datao_clear) begin
        r_buf <= 8'd0;
      end

      if (w_sel && iobus_cono_set) begin
        r_pia <= w_pia_base | iobus_iob_in[33:35];
      end else if (w_sel && iobus_cono_clear) begin
        r_pia <= 3'd0;
      end

      if (w_sel && iobus_cono_set) begin
        if (iobus_iob_in[32]) r_done <= 1'b0;
        if (iobus_iob_in[31]) r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    w_iob_out = '0;
    if (w_sel && iobus_iob_fm_status) begin
      w_iob_out[31]    = r_busy;
      w_iob_out[32]    = r_done;
      w_iob_out[33:35] = r_pia;
    end
  end

  for (genvar k = 1; k <= 7; k++) begin : g_pi
    assign iobus_pi_req[k] = r_done && (r_pia == 3'(k));
  end

  assign iobus_iob_out  = w_iob_out;
  assign iobus_dr_split = 1'b0;
  assign iobus_rdi_data = 1'b0;
  assign txd            = r_txd;

endmodule
`default_nettype wire
